i2c_frame_timer: RTL and testbench
==================================

// Module: i2c_frame_timer
// PURPOSE
//  Parametrised successor to the I2C slave byte timer. Tracks SCL edges into frames of DATA_BITS + 1 ack slot.
//  Adds an address phase with match/no-match handling, a latched R/W direction, transmit-side master-NACK detection
//  and abort on mid-frame START/STOP. Sits between the SCL/SDA edge detector and the slave shift registers/controller.
// PARAMETERS
//  DATA_BITS  8  bits per frame before the ack slot (>=2)
//  CNT_W      $clog2(DATA_BITS+1)  bit counter width (derived, do not override)
//  FCNT_W     8  width of saturating frame counter
// PORTS
//  clk            in   1       system clock
//  rst            in   1       synchronous reset, active-high
//  start          in   1       START/repeated-START detected (1-cycle pulse)
//  stop           in   1       STOP detected (1-cycle pulse)
//  rising_edge    in   1       SCL rising edge (1-cycle pulse)
//  falling_edge   in   1       SCL falling edge (1-cycle pulse)
//  sda_in         in   1       synchronised SDA level
//  address_match  in   1       level from address compare, valid when last address bit is shifted in
//  bit_index      out  CNT_W   data bits sampled so far in current frame (0..DATA_BITS)
//  shift_en       out  1       pulse: sample SDA into rx shift register
//  load_tx        out  1       pulse: load next tx byte (tx mode only)
//  byte_received  out  1       pulse: DATA_BITS bits complete
//  ack_drive      out  1       level: slave pulls SDA low (ack slot, rx/addr frames)
//  ack_prep       out  1       level: in ACK_PREP
//  ack_check      out  1       level: in ACK_CHECK
//  ack_done       out  1       level: in ACK_DONE
//  addr_phase     out  1       level: current frame is the address frame
//  tx_mode        out  1       level: latched R/W bit (1 = slave transmits)
//  master_nack    out  1       pulse: master NACKed a tx frame
//  abort          out  1       pulse: START/STOP arrived mid-frame
//  frame_count    out  FCNT_W  frames acked since START, saturates at all-ones
// BEHAVIOUR
//  - Reset (rst=1 at posedge clk): state IDLE; all outputs, counters and tx_mode = 0.
//  - States: IDLE, ARMED, DATA, ACK_PREP, ACK_CHECK, ACK_DONE, HOLD.
//  - IDLE --start--> ARMED. addr_phase=1, bit_cnt=0, frame_count=0.
//  - ARMED --rising--> DATA. bit_cnt=1, shift_en pulse.
//  - DATA --rising with bit_cnt<DATA_BITS--> bit_cnt+1, shift_en pulse.
//    Rising at bit_cnt==DATA_BITS is ignored.
//  - DATA --falling with bit_cnt==DATA_BITS-->:
//      addr frame, address_match=1: ACK_PREP; latch tx_mode=sda_in-sampled LSB (last shifted bit).
//      addr frame, address_match=0: HOLD; no ack and no byte_received.
//      data frame: ACK_PREP.
//  - ACK_PREP --rising--> ACK_CHECK. In tx data frames, sample sda_in on this rising edge:
//    1 = NACK -> master_nack pulse, nack flag set.
//  - ACK_CHECK --falling--> HOLD if nack flag set; otherwise ACK_DONE with frame_count+1 (saturating)
//    and addr_phase cleared.
//  - ACK_DONE --rising--> DATA, bit_cnt=1, shift_en pulse.
//  - HOLD ignores SCL edges; leaves only on start/stop.
//  - ack_drive = 1 in ACK_PREP/ACK_CHECK when addr_phase=1 or tx_mode=0; otherwise 0.
//  - load_tx pulses on entry to ACK_DONE when tx_mode=1, including the address frame (it loads the 1st tx byte).
//  - Timing: pulse outputs are registered and asserted for exactly one cycle, on the clk edge after the
//    triggering input pulse. Level outputs decode the state register.
//  - byte_received pulses together with entry to ACK_PREP.
//  - stop in any non-IDLE state -> IDLE, tx_mode cleared.
//  - start in any non-IDLE state -> ARMED, as from IDLE.
//  - abort pulses when stop/start arrives in DATA with bit_cnt>0, ACK_PREP or ACK_CHECK.
//  - Priority: rst > stop > start > SCL edges. Simultaneous start+stop acts as stop.
//    start/stop coincident with an SCL edge: the edge is dropped.
//  - rising_edge and falling_edge together (illegal): falling_edge is ignored.
// STRUCTURE
//  - i2c_pkg: frame_state_t enum (4-bit); I2C_ACK=1'b0 and I2C_NACK=1'b1 constants.
//  - One sub-module: i2c_bit_counter (CNT_W, clear/inc/terminal-count at DATA_BITS).
//    FSM, flags and frame counter stay in this file.
// TESTING
//  1. Reset: rst=1 for 2 cycles, random inputs -> every output 0, FSM in IDLE.
//  2. Rx write, DATA_BITS=8: start; addr 0x54 (R/W=0) with match; then 2 bytes.
//     -> shift_en x8 per frame; byte_received x3; ack_drive in each ack slot; frame_count=3; tx_mode=0.
//  3. Address miss: start; addr with address_match=0 -> HOLD; no byte_received/ack_drive;
//     later SCL edges ignored; stop -> IDLE.
//  4. Tx read: addr R/W=1 matched -> load_tx in ACK_DONE; tx frame; sda_in=1 at ack rising
//     -> master_nack pulse, then HOLD; stop -> IDLE, tx_mode=0.
//  5. Abort: repeated start after 4th data bit -> abort pulse, ARMED, addr_phase=1, bit_index=0.
//     Also start+stop in the same cycle -> IDLE.
//  6. Sweep: DATA_BITS=9, FCNT_W=2; 5 frames -> byte_received after 9 bits; frame_count saturates at 3.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and bus-level constants for the I2C slave frame timer.
package i2c_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ARMED     = 4'd1,
        S_DATA      = 4'd2,
        S_ACK_PREP  = 4'd3,
        S_ACK_CHECK = 4'd4,
        S_ACK_DONE  = 4'd5,
        S_HOLD      = 4'd6
    } frame_state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_bit_counter.sv
// Per-frame bit counter; stops at DATA_BITS and flags the terminal count.
module i2c_bit_counter #(
    parameter int DATA_BITS = 8,
    parameter int CNT_W     = $clog2(DATA_BITS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(DATA_BITS);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [CNT_W-1:0] r_count;

    // clear together with inc restarts the count at the first bit of a new frame
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= inc ? ONE : '0;
        end else if (inc && (r_count != TERMINAL)) begin
            r_count <= r_count + ONE;
        end
    end

    assign count = r_count;
    assign tc    = (r_count == TERMINAL);

endmodule

// File: rtl/i2c_frame_timer.sv
// Slave-side I2C frame sequencer: bit timing, address phase, ack slot handling and abort detection.
module i2c_frame_timer
    import i2c_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int CNT_W     = $clog2(DATA_BITS + 1),
    parameter int FCNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              rising_edge,
    input  logic              falling_edge,
    input  logic              sda_in,
    input  logic              address_match,
    output logic [CNT_W-1:0]  bit_index,
    output logic              shift_en,
    output logic              load_tx,
    output logic              byte_received,
    output logic              ack_drive,
    output logic              ack_prep,
    output logic              ack_check,
    output logic              ack_done,
    output logic              addr_phase,
    output logic              tx_mode,
    output logic              master_nack,
    output logic              abort,
    output logic [FCNT_W-1:0] frame_count
);

    frame_state_t      r_state;
    logic              r_shift_en;
    logic              r_load_tx;
    logic              r_byte_rx;
    logic              r_master_nack;
    logic              r_abort;
    logic              r_addr_phase;
    logic              r_tx_mode;
    logic              r_nack;
    logic              r_last_sda;
    logic [FCNT_W-1:0] r_frame_count;

    logic              w_rise;
    logic              w_fall;
    logic              w_cnt_clear;
    logic              w_cnt_inc;
    logic              w_cnt_tc;
    logic [CNT_W-1:0]  w_bit_cnt;
    logic              w_midframe;

    function automatic logic [FCNT_W-1:0] sat_inc(input logic [FCNT_W-1:0] v);
        return (&v) ? v : v + FCNT_W'(1);
    endfunction

    // simultaneous SCL edges are illegal; the rising edge wins
    assign w_rise = rising_edge;
    assign w_fall = falling_edge & ~rising_edge;

    assign w_midframe = ((r_state == S_DATA) && (w_bit_cnt != '0)) ||
                        (r_state == S_ACK_PREP) || (r_state == S_ACK_CHECK);

    always_comb begin
        w_cnt_clear = 1'b0;
        w_cnt_inc   = 1'b0;
        if (stop || start) begin
            w_cnt_clear = 1'b1;
        end else if (w_rise) begin
            case (r_state)
                S_ARMED, S_ACK_DONE: begin
                    w_cnt_clear = 1'b1;
                    w_cnt_inc   = 1'b1;
                end
                S_DATA:  w_cnt_inc = ~w_cnt_tc;
                default: ;
            endcase
        end
    end

    i2c_bit_counter #(
        .DATA_BITS (DATA_BITS),
        .CNT_W     (CNT_W)
    ) u_bit_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (w_cnt_clear),
        .inc   (w_cnt_inc),
        .count (w_bit_cnt),
        .tc    (w_cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_shift_en    <= 1'b0;
            r_load_tx     <= 1'b0;
            r_byte_rx     <= 1'b0;
            r_master_nack <= 1'b0;
            r_abort       <= 1'b0;
            r_addr_phase  <= 1'b0;
            r_tx_mode     <= 1'b0;
            r_nack        <= 1'b0;
            r_last_sda    <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_shift_en    <= 1'b0;
            r_load_tx     <= 1'b0;
            r_byte_rx     <= 1'b0;
            r_master_nack <= 1'b0;
            r_abort       <= 1'b0;
            if (stop) begin
                if (r_state != S_IDLE) begin
                    r_abort      <= w_midframe;
                    r_state      <= S_IDLE;
                    r_tx_mode    <= 1'b0;
                    r_addr_phase <= 1'b0;
                    r_nack       <= 1'b0;
                end
            end else if (start) begin
                r_abort       <= w_midframe;
                r_state       <= S_ARMED;
                r_addr_phase  <= 1'b1;
                r_nack        <= 1'b0;
                r_frame_count <= '0;
            end else begin
                case (r_state)
                    S_ARMED, S_ACK_DONE: begin
                        if (w_rise) begin
                            r_state    <= S_DATA;
                            r_shift_en <= 1'b1;
                            r_last_sda <= sda_in;
                        end
                    end
                    S_DATA: begin
                        if (w_rise && !w_cnt_tc) begin
                            r_shift_en <= 1'b1;
                            r_last_sda <= sda_in;
                        end else if (w_fall && w_cnt_tc) begin
                            if (r_addr_phase && !address_match) begin
                                r_state <= S_HOLD;
                            end else begin
                                r_state   <= S_ACK_PREP;
                                r_byte_rx <= 1'b1;
                                // R/W is the last bit of the address frame
                                if (r_addr_phase) begin
                                    r_tx_mode <= r_last_sda;
                                end
                            end
                        end
                    end
                    S_ACK_PREP: begin
                        if (w_rise) begin
                            r_state <= S_ACK_CHECK;
                            if (r_tx_mode && !r_addr_phase && (sda_in == I2C_NACK)) begin
                                r_master_nack <= 1'b1;
                                r_nack        <= 1'b1;
                            end
                        end
                    end
                    S_ACK_CHECK: begin
                        if (w_fall) begin
                            if (r_nack) begin
                                r_state <= S_HOLD;
                            end else begin
                                r_state       <= S_ACK_DONE;
                                r_frame_count <= sat_inc(r_frame_count);
                                r_addr_phase  <= 1'b0;
                                r_load_tx     <= r_tx_mode;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bit_index     = w_bit_cnt;
    assign shift_en      = r_shift_en;
    assign load_tx       = r_load_tx;
    assign byte_received = r_byte_rx;
    assign master_nack   = r_master_nack;
    assign abort         = r_abort;
    assign addr_phase    = r_addr_phase;
    assign tx_mode       = r_tx_mode;
    assign frame_count   = r_frame_count;
    assign ack_prep      = (r_state == S_ACK_PREP);
    assign ack_check     = (r_state == S_ACK_CHECK);
    assign ack_done      = (r_state == S_ACK_DONE);
    assign ack_drive     = (ack_prep || ack_check) && (r_addr_phase || !r_tx_mode);

endmodule

// File: tb/tb_i2c_frame_timer.sv
// Directed bench for i2c_frame_timer: an 8-bit instance and a 9-bit/2-bit-counter instance on shared stimulus.
module tb_i2c_frame_timer;

    logic clk = 1'b0;
    logic rst, start, stop, rising_edge, falling_edge, sda_in, address_match;

    logic [3:0] bidx8;
    logic       sh8, ld8, br8, ad8, ap8, ac8, adn8, aph8, tx8, mn8, ab8;
    logic [7:0] fc8;

    logic [3:0] bidx9;
    logic       sh9, ld9, br9, ad9, ap9, ac9, adn9, aph9, tx9, mn9, ab9;
    logic [1:0] fc9;

    int n_pass  = 0;
    int n_total = 0;

    int c_shift8 = 0, c_byte8 = 0, c_load8 = 0, c_nack8 = 0, c_abort8 = 0, c_ackd8 = 0;
    int c_byte9  = 0;
    logic prev_ad8 = 1'b0;

    always #5 clk = ~clk;

    i2c_frame_timer #(.DATA_BITS(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .rising_edge(rising_edge), .falling_edge(falling_edge),
        .sda_in(sda_in), .address_match(address_match),
        .bit_index(bidx8), .shift_en(sh8), .load_tx(ld8), .byte_received(br8),
        .ack_drive(ad8), .ack_prep(ap8), .ack_check(ac8), .ack_done(adn8),
        .addr_phase(aph8), .tx_mode(tx8), .master_nack(mn8), .abort(ab8),
        .frame_count(fc8)
    );

    i2c_frame_timer #(.DATA_BITS(9), .FCNT_W(2)) u_dut9 (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .rising_edge(rising_edge), .falling_edge(falling_edge),
        .sda_in(sda_in), .address_match(address_match),
        .bit_index(bidx9), .shift_en(sh9), .load_tx(ld9), .byte_received(br9),
        .ack_drive(ad9), .ack_prep(ap9), .ack_check(ac9), .ack_done(adn9),
        .addr_phase(aph9), .tx_mode(tx9), .master_nack(mn9), .abort(ab9),
        .frame_count(fc9)
    );

    always @(negedge clk) begin
        if (sh8) c_shift8++;
        if (br8) c_byte8++;
        if (ld8) c_load8++;
        if (mn8) c_nack8++;
        if (ab8) c_abort8++;
        if (ad8 && !prev_ad8) c_ackd8++;
        prev_ad8 = ad8;
        if (br9) c_byte9++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    task automatic rise(input logic b);
        sda_in = b; rising_edge = 1'b1; tick(); rising_edge = 1'b0; tick();
    endtask

    task automatic fall();
        falling_edge = 1'b1; tick(); falling_edge = 1'b0; tick();
    endtask

    task automatic send_bits(input logic [8:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            rise(v[i]);
            fall();
        end
    endtask

    task automatic ack_slot(input logic b);
        rise(b);
        fall();
    endtask

    int s_shift, s_byte, s_load, s_nack, s_abort, s_ackd, s_byte9;

    task automatic snap();
        s_shift = c_shift8; s_byte = c_byte8; s_load = c_load8;
        s_nack = c_nack8; s_abort = c_abort8; s_ackd = c_ackd8; s_byte9 = c_byte9;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; rising_edge = 1'b0;
        falling_edge = 1'b0; sda_in = 1'b0; address_match = 1'b0;

        // reset with random inputs
        for (int i = 0; i < 2; i++) begin
            start = 1'($urandom); stop = 1'($urandom); rising_edge = 1'($urandom);
            falling_edge = 1'($urandom); sda_in = 1'($urandom); address_match = 1'($urandom);
            tick();
        end
        chk("rst_outs8", 32'({bidx8, sh8, ld8, br8, ad8, ap8, ac8, adn8, aph8, tx8, mn8, ab8, fc8}), 0);
        chk("rst_outs9", 32'({bidx9, sh9, ld9, br9, ad9, ap9, ac9, adn9, aph9, tx9, mn9, ab9, fc9}), 0);
        rst = 1'b0; start = 1'b0; stop = 1'b0; rising_edge = 1'b0;
        falling_edge = 1'b0; sda_in = 1'b0; address_match = 1'b0;
        tick();
        chk("idle_outs8", 32'({bidx8, sh8, ld8, br8, ad8, ap8, ac8, adn8, aph8, tx8, mn8, ab8, fc8}), 0);

        // rx write: address 0x54 matched, then two data bytes
        snap();
        address_match = 1'b1;
        do_start();
        chk("wr_start_aph", 32'(aph8), 1);
        chk("wr_start_bidx", 32'(bidx8), 0);
        send_bits(9'h054, 8);
        chk("wr_addr_ackprep", 32'(ap8), 1);
        chk("wr_addr_ackdrv", 32'(ad8), 1);
        chk("wr_addr_bidx", 32'(bidx8), 8);
        ack_slot(1'b0);
        chk("wr_addr_ackdone", 32'(adn8), 1);
        chk("wr_addr_aph_clr", 32'(aph8), 0);
        chk("wr_fc1", 32'(fc8), 1);
        send_bits(9'h0A5, 8);
        chk("wr_d1_ackdrv", 32'(ad8), 1);
        ack_slot(1'b0);
        send_bits(9'h03C, 8);
        ack_slot(1'b0);
        chk("wr_shift_cnt", 32'(c_shift8 - s_shift), 24);
        chk("wr_byte_cnt", 32'(c_byte8 - s_byte), 3);
        chk("wr_ackdrv_cnt", 32'(c_ackd8 - s_ackd), 3);
        chk("wr_fc3", 32'(fc8), 3);
        chk("wr_txmode", 32'(tx8), 0);
        chk("wr_load_cnt", 32'(c_load8 - s_load), 0);
        do_stop();
        chk("wr_stop_abort", 32'(c_abort8 - s_abort), 0);
        chk("wr_stop_idle", 32'({ad8, ap8, ac8, adn8, aph8, tx8}), 0);

        // address miss
        snap();
        address_match = 1'b0;
        do_start();
        send_bits(9'h054, 8);
        chk("miss_byte_cnt", 32'(c_byte8 - s_byte), 0);
        chk("miss_ackprep", 32'(ap8), 0);
        rise(1'b1);
        fall();
        rise(1'b0);
        chk("miss_shift_cnt", 32'(c_shift8 - s_shift), 8);
        chk("miss_ackdrv_cnt", 32'(c_ackd8 - s_ackd), 0);
        chk("miss_bidx", 32'(bidx8), 8);
        do_stop();
        chk("miss_stop_bidx", 32'(bidx8), 0);
        chk("miss_stop_aph", 32'(aph8), 0);
        chk("miss_stop_abort", 32'(c_abort8 - s_abort), 0);

        // tx read: address 0xA3 (R/W=1), one tx frame NACKed by master
        snap();
        address_match = 1'b1;
        do_start();
        send_bits(9'h0A3, 8);
        chk("rd_txmode", 32'(tx8), 1);
        chk("rd_addr_ackdrv", 32'(ad8), 1);
        ack_slot(1'b0);
        chk("rd_load_cnt", 32'(c_load8 - s_load), 1);
        chk("rd_ackdone", 32'(adn8), 1);
        send_bits(9'h0FF, 8);
        chk("rd_d_ackprep", 32'(ap8), 1);
        chk("rd_d_ackdrv", 32'(ad8), 0);
        rise(1'b1);
        chk("rd_nack_cnt", 32'(c_nack8 - s_nack), 1);
        chk("rd_ackcheck", 32'(ac8), 1);
        fall();
        chk("rd_hold", 32'({ap8, ac8, adn8}), 0);
        chk("rd_fc", 32'(fc8), 1);
        chk("rd_load_cnt2", 32'(c_load8 - s_load), 1);
        do_stop();
        chk("rd_stop_tx", 32'(tx8), 0);

        // abort by repeated start mid-frame, then start+stop together
        snap();
        do_start();
        send_bits(9'h054, 8);
        ack_slot(1'b0);
        send_bits(9'h00F, 4);
        start = 1'b1; tick(); start = 1'b0;
        chk("ab_pulse", 32'(ab8), 1);
        chk("ab_aph", 32'(aph8), 1);
        chk("ab_bidx", 32'(bidx8), 0);
        chk("ab_fc", 32'(fc8), 0);
        tick();
        chk("ab_one_cycle", 32'(ab8), 0);
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        chk("ss_idle_aph", 32'(aph8), 0);
        chk("ss_abort_cnt", 32'(c_abort8 - s_abort), 1);

        // 9-bit frames, 2-bit saturating frame counter
        snap();
        do_start();
        send_bits(9'h0A8, 9);
        chk("sw_ackprep9", 32'(ap9), 1);
        chk("sw_bidx9", 32'(bidx9), 9);
        ack_slot(1'b0);
        chk("sw_fc1", 32'(fc9), 1);
        send_bits(9'h155, 9);
        ack_slot(1'b0);
        send_bits(9'h0AA, 9);
        ack_slot(1'b0);
        chk("sw_fc3", 32'(fc9), 3);
        send_bits(9'h1FF, 9);
        ack_slot(1'b0);
        send_bits(9'h001, 9);
        ack_slot(1'b0);
        chk("sw_fc_sat", 32'(fc9), 3);
        chk("sw_ackdone", 32'(adn9), 1);
        chk("sw_byte_cnt", 32'(c_byte9 - s_byte9), 5);
        do_stop();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
